reg_mask_encoder: RTL and testbench
===================================

# reg_mask_encoder

Sequential 32-to-5 encoder that walks a 32-bit register mask and emits the index of each set bit, lowest first, one per handshake. It is the inverse of the register-select decoder. It drives multi-register sequences: context save/restore, and scoreboard drain of pending write-backs. Each emitted 5-bit index can feed the register file port selects directly.

## Interface
- No parameters; mask width fixed at 32, index width fixed at 5.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- load  in  1  start a walk with mask_in; accepted only in IDLE
- mask_in  in  32  register mask, bit n = register Xn
- abort  in  1  synchronous cancel of the current walk
- ready  in  1  consumer accepts idx this cycle
- valid  out  1  idx holds a pending register index
- idx  out  5  lowest set bit of remaining mask; 0 when valid=0
- remaining  out  6  popcount of remaining mask (0..32)
- busy  out  1  walk in progress (WALK or DONE state)
- done  out  1  one-cycle pulse after the last index is accepted

## Operation
- State register with states IDLE, WALK and DONE, plus a 32-bit mask_reg and a 6-bit remaining counter.
- Reset values: state=IDLE, mask_reg=0, remaining=0, valid=0, idx=0, busy=0, done=0.
- IDLE:
  - If load=1 and abort=0: mask_reg←mask_in and remaining←popcount(mask_in).
  - If mask_in≠0, go to WALK. If mask_in=0, go to DONE (zero-length walk, no valid).
  - load is ignored in WALK and DONE.
- WALK:
  - valid=1 and idx=index of the lowest set bit of mask_reg, both derived from registered state.
  - On valid&ready: clear that bit in mask_reg and decrement remaining.
  - If it was the last set bit, go to DONE; otherwise stay in WALK.
  - While ready=0, idx and valid hold steady.
- DONE: done=1 for exactly one cycle, busy=1, valid=0, then go to IDLE.
- abort=1 in WALK or DONE:
  - Next state is IDLE, mask_reg←0, remaining←0, no done pulse.
  - abort takes priority over an accept in the same cycle; that index counts as not consumed.
- abort together with load in IDLE: abort wins, the load is dropped, and the block stays IDLE.
- busy=1 exactly when state is WALK or DONE.
- Priority encoding is fixed lowest-index-first. Bit 31 maps to idx=31 (5'b11111), with no wrap.
- remaining always equals popcount(mask_reg). It is 0 in IDLE and DONE.

## Timing
- Load latency: load sampled at edge k gives valid=1 with the first idx in the cycle after edge k.
- Throughput: with ready held high, one index per cycle. A mask with N set bits produces N accepts on consecutive edges k+1..k+N.
- done is high in the cycle after the edge that accepts the last index. IDLE follows one cycle later.
- Earliest next load is the cycle after done, i.e. the first IDLE cycle.
- Zero mask: load at edge k gives done=1 in cycle k+1, with valid never asserted.
- ready deasserted mid-walk: outputs are frozen, no index is skipped and none is repeated.
- The accept condition is valid&ready sampled at the rising edge. ready has no effect when valid=0.
- Asynchronous rst forces the reset values immediately, including mid-walk and during done. The walk is lost.
- All outputs are glitch-free functions of registered state only, with no combinational path from inputs to outputs.

## Test plan
- Reset then load mask_in=32'h0000_0000 -> no valid ever; done=1 in the cycle after load; busy=1 for that cycle only; remaining=0.
- Load 32'h8000_0013 with ready=1 -> idx sequence 0,1,4,31 on four consecutive cycles; remaining 4,3,2,1; done pulse in the next cycle; then IDLE.
- Load 32'hFFFF_FFFF and toggle ready every other cycle -> idx 0..31 each accepted exactly once in order; idx is stable while ready=0; exactly 32 accepts before done.
- Load 32'h0000_0F00, accept idx 8, then assert abort with ready=1 while idx=9 -> IDLE next cycle, no done, remaining=0; a later load of 32'h1 yields idx=0.
- Assert load with a new mask while in WALK -> ignored; the original sequence completes unchanged. Assert load and abort together in IDLE -> stays IDLE, valid=0.
- Assert rst asynchronously mid-walk, between clock edges, with mask 32'h00F0_0000 -> valid, busy, done, idx and remaining drop to 0 immediately; the next load behaves as from a fresh reset.

Source files
------------

// File: rtl/reg_mask_encoder.sv
// Sequential 32-to-5 encoder: walks a register mask lowest-bit-first and
// hands out one register index per valid/ready handshake.
module reg_mask_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] mask_in,
    input  logic        abort,
    input  logic        ready,
    output logic        valid,
    output logic [4:0]  idx,
    output logic [5:0]  remaining,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] mask_reg, mask_n;
    logic [5:0]  remaining_n;
    logic        accept;

    function automatic logic [5:0] popcount32(input logic [31:0] m);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {5'd0, m[i]};
        end
        return cnt;
    endfunction

    // Scan from the top so the lowest set bit is the last one written.
    function automatic logic [4:0] lowest_set(input logic [31:0] m);
        logic [4:0] pos;
        pos = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (m[i]) begin
                pos = 5'(i);
            end
        end
        return pos;
    endfunction

    assign accept = valid & ready;

    always_comb begin
        state_n     = state;
        mask_n      = mask_reg;
        remaining_n = remaining;
        unique case (state)
            IDLE: begin
                if (load && !abort) begin
                    mask_n      = mask_in;
                    remaining_n = popcount32(mask_in);
                    state_n     = (mask_in != 32'd0) ? WALK : DONE;
                end
            end
            WALK: begin
                if (abort) begin
                    state_n     = IDLE;
                    mask_n      = 32'd0;
                    remaining_n = 6'd0;
                end else if (accept) begin
                    // Clearing the lowest set bit: m & (m - 1).
                    mask_n      = mask_reg & (mask_reg - 32'd1);
                    remaining_n = remaining - 6'd1;
                    if (remaining == 6'd1) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                state_n     = IDLE;
                mask_n      = 32'd0;
                remaining_n = 6'd0;
            end
            default: begin
                state_n     = IDLE;
                mask_n      = 32'd0;
                remaining_n = 6'd0;
            end
        endcase
    end

    // Outputs are registered from the next state so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mask_reg  <= 32'd0;
            remaining <= 6'd0;
            valid     <= 1'b0;
            idx       <= 5'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            mask_reg  <= mask_n;
            remaining <= remaining_n;
            valid     <= (state_n == WALK);
            idx       <= (state_n == WALK) ? lowest_set(mask_n) : 5'd0;
            busy      <= (state_n != IDLE);
            done      <= (state_n == DONE) && !(state == DONE);
        end
    end

endmodule

// File: tb/tb_reg_mask_encoder.sv
// Directed self-checking bench for reg_mask_encoder.
module tb_reg_mask_encoder;

    logic        clk;
    logic        rst;
    logic        load;
    logic [31:0] mask_in;
    logic        abort;
    logic        ready;
    logic        valid;
    logic [4:0]  idx;
    logic [5:0]  remaining;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;

    reg_mask_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .mask_in   (mask_in),
        .abort     (abort),
        .ready     (ready),
        .valid     (valid),
        .idx       (idx),
        .remaining (remaining),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, {31'd0, valid}, 32'd0);
        check({tag, ".busy"},  {31'd0, busy},  32'd0);
        check({tag, ".done"},  {31'd0, done},  32'd0);
        check({tag, ".idx"},   {27'd0, idx},   32'd0);
        check({tag, ".rem"},   {26'd0, remaining}, 32'd0);
    endtask

    task automatic check_walk(input string tag, input int exp_idx, input int exp_rem);
        check({tag, ".valid"}, {31'd0, valid}, 32'd1);
        check({tag, ".busy"},  {31'd0, busy},  32'd1);
        check({tag, ".idx"},   {27'd0, idx},   32'(exp_idx));
        check({tag, ".rem"},   {26'd0, remaining}, 32'(exp_rem));
    endtask

    task automatic check_done(input string tag);
        check({tag, ".done"},  {31'd0, done},  32'd1);
        check({tag, ".busy"},  {31'd0, busy},  32'd1);
        check({tag, ".valid"}, {31'd0, valid}, 32'd0);
        check({tag, ".rem"},   {26'd0, remaining}, 32'd0);
    endtask

    initial begin
        int seq_a [4];
        n_checks = 0;
        n_fail   = 0;
        seq_a    = '{0, 1, 4, 31};

        rst = 1'b1; load = 1'b0; mask_in = 32'd0; abort = 1'b0; ready = 1'b0;
        #12;
        check_idle("reset");
        tick();
        rst = 1'b0;
        tick();
        check_idle("post_reset");

        // Zero-length walk.
        load = 1'b1; mask_in = 32'h0000_0000;
        tick();
        load = 1'b0;
        check_done("zero");
        tick();
        check_idle("zero_after");

        // Sparse mask with ready held high.
        load = 1'b1; mask_in = 32'h8000_0013; ready = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_walk($sformatf("sparse%0d", k), seq_a[k], 4 - k);
            tick();
        end
        check_done("sparse_done");
        tick();
        check_idle("sparse_idle");

        // Full mask with ready toggling.
        ready = 1'b0; load = 1'b1; mask_in = 32'hFFFF_FFFF;
        tick();
        load = 1'b0;
        for (int k = 0; k < 32; k++) begin
            check_walk($sformatf("full%0d", k), k, 32 - k);
            ready = 1'b0;
            tick();
            check_walk($sformatf("full_hold%0d", k), k, 32 - k);
            ready = 1'b1;
            tick();
        end
        ready = 1'b0;
        check_done("full_done");
        tick();
        check_idle("full_idle");

        // Abort mid-walk while an accept is offered.
        ready = 1'b1; load = 1'b1; mask_in = 32'h0000_0F00;
        tick();
        load = 1'b0;
        check_walk("abort_a", 8, 4);
        tick();
        check_walk("abort_b", 9, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort_now");
        tick();
        check_idle("abort_next");
        load = 1'b1; mask_in = 32'h0000_0001;
        tick();
        load = 1'b0;
        check_walk("reload", 0, 1);
        tick();
        check_done("reload_done");
        tick();
        check_idle("reload_idle");

        // Load during WALK is ignored.
        ready = 1'b0; load = 1'b1; mask_in = 32'h0000_0006;
        tick();
        mask_in = 32'hFFFF_FFFF;
        tick();
        load = 1'b0;
        check_walk("ign_hold", 1, 2);
        ready = 1'b1;
        tick();
        check_walk("ign_b", 2, 1);
        tick();
        check_done("ign_done");
        tick();
        check_idle("ign_idle");

        // Load with abort in IDLE stays IDLE.
        load = 1'b1; abort = 1'b1; mask_in = 32'h0000_00FF;
        tick();
        load = 1'b0; abort = 1'b0;
        check_idle("ld_abort");
        tick();
        check_idle("ld_abort2");

        // Asynchronous reset between edges mid-walk.
        load = 1'b1; mask_in = 32'h00F0_0000;
        tick();
        load = 1'b0;
        check_walk("arst_a", 20, 4);
        tick();
        check_walk("arst_b", 21, 3);
        #2;
        rst = 1'b1;
        #1;
        check_idle("arst_now");
        #1;
        rst = 1'b0;
        tick();
        check_idle("arst_after");
        load = 1'b1; mask_in = 32'h00F0_0000;
        tick();
        load = 1'b0;
        check_walk("arst_reload", 20, 4);
        tick();
        check_walk("arst_reload2", 21, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
